// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction width, reset/NOP defaults,
// and opcode/func encodings used by fetch, decode and control.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: address out, data and ready back.
interface if_stage_if;
    import mips_pkg::*;

    logic [INSTR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds IR, nextInst and id_valid; supports hold,
// flush (NOP + new PC+4) and bubble (NOP, PC+4 kept) on top of a normal load.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc4_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic [INSTR_W-1:0] next_inst_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [INSTR_W-1:0] next_inst_q, next_inst_d;
    logic               valid_q, valid_d;

    // Next-state selection; anything that is neither hold nor load inserts a NOP.
    always_comb begin
        ir_d        = ir_q;
        next_inst_d = next_inst_q;
        valid_d     = valid_q;
        if (hold_i) begin
            ir_d        = ir_q;
            next_inst_d = next_inst_q;
            valid_d     = valid_q;
        end else if (flush_i) begin
            ir_d        = NOP_INSTR;
            next_inst_d = pc4_i;
            valid_d     = 1'b0;
        end else if (load_i) begin
            ir_d        = instr_i;
            next_inst_d = pc4_i;
            valid_d     = 1'b1;
        end else begin
            ir_d        = NOP_INSTR;
            next_inst_d = next_inst_q;
            valid_d     = 1'b0;
        end
    end

    // Register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q        <= NOP_INSTR;
            next_inst_q <= 32'h0000_0000;
            valid_q     <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            next_inst_q <= next_inst_d;
            valid_q     <= valid_d;
        end
    end

    assign ir_o        = ir_q;
    assign next_inst_o = next_inst_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection (stall,
// branch/jump redirect, memory wait, sequential) and the IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PcSrc,
    input  logic               jump,
    input  logic [INSTR_W-1:0] beqAdr,
    input  logic [25:0]        jmpAdr,
    if_stage_if.master         imem,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] IR,
    output logic [INSTR_W-1:0] nextInst,
    output logic               id_valid
);

    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] pc_plus4_s;
    logic [INSTR_W-1:0] jump_tgt_s;
    logic [INSTR_W-1:0] redirect_tgt_s;
    logic               redirect_s;
    logic               load_s;

    assign pc_plus4_s     = pc_q + 32'd4;
    // Jump target takes its upper nibble from the PC+4 of the jump sitting in IF/ID.
    assign jump_tgt_s     = {nextInst[31:28], jmpAdr, 2'b00};
    assign redirect_s     = (PcSrc | jump) & ~stall;
    assign redirect_tgt_s = jump ? jump_tgt_s : beqAdr;
    assign load_s         = imem.imem_ready;

    // Next-PC priority: stall, redirect, memory wait, sequential.
    always_comb begin
        pc_d = pc_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect_s) begin
            pc_d = redirect_tgt_s;
        end else if (!imem.imem_ready) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // PC register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc             = pc_q;
    assign imem.imem_addr = pc_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (stall),
        .flush_i     (redirect_s),
        .load_i      (load_s),
        .instr_i     (imem.imem_rdata),
        .pc4_i       (pc_plus4_s),
        .ir_o        (IR),
        .next_inst_o (nextInst),
        .valid_o     (id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed + randomized bench for if_stage against a rule-level fetch model.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, PcSrc, jump, ready_r;
    logic [31:0] beqAdr;
    logic [25:0] jmpAdr;
    logic [31:0] pc, IR, nextInst;
    logic        id_valid;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc, m_ir, m_next;
    logic        m_valid;

    if_stage_if imem ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2001_0005;
        if (a == 32'h0000_0004) return 32'h2002_0007;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign imem.imem_rdata = mem_word(imem.imem_addr);
    assign imem.imem_ready = ready_r;

    if_stage dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .PcSrc    (PcSrc),
        .jump     (jump),
        .beqAdr   (beqAdr),
        .jmpAdr   (jmpAdr),
        .imem     (imem),
        .pc       (pc),
        .IR       (IR),
        .nextInst (nextInst),
        .id_valid (id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".imem_addr"}, imem.imem_addr, m_pc);
        chk({tag, ".IR"}, IR, m_ir);
        chk({tag, ".nextInst"}, nextInst, m_next);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_ir = 32'h0000_0000; m_next = 32'h0000_0000; m_valid = 1'b0;
    endtask

    // One clock: drive inputs, apply the fetch rules to the model, check after the edge.
    task automatic step(input string tag, input logic s, input logic br, input logic j,
                        input logic [31:0] ba, input logic [25:0] ja, input logic rdy);
        logic [31:0] n_pc, n_ir, n_next, tgt;
        logic        n_valid;
        stall = s; PcSrc = br; jump = j; beqAdr = ba; jmpAdr = ja; ready_r = rdy;
        n_pc = m_pc; n_ir = m_ir; n_next = m_next; n_valid = m_valid;
        tgt = j ? {m_next[31:28], ja, 2'b00} : ba;
        if (s) begin
            // everything holds
        end else if (br || j) begin
            n_pc = tgt; n_ir = 32'h0000_0000; n_valid = 1'b0; n_next = m_pc + 32'd4;
        end else if (!rdy) begin
            n_ir = 32'h0000_0000; n_valid = 1'b0;
        end else begin
            n_ir = mem_word(m_pc); n_next = m_pc + 32'd4; n_valid = 1'b1; n_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        m_pc = n_pc; m_ir = n_ir; m_next = n_next; m_valid = n_valid;
        #1;
        chk_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; PcSrc = 1'b0; jump = 1'b0;
        beqAdr = 32'h0; jmpAdr = 26'h0; ready_r = 1'b1;
        model_reset();
        #1;
        chk_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset_held");
        rst = 1'b1;

        // straight-line fetch
        step("fetch0", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("fetch0.IR_lit", IR, 32'h2001_0005);
        step("fetch1", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("fetch1.IR_lit", IR, 32'h2002_0007);
        chk("fetch1.pc_lit", pc, 32'h0000_0008);

        // stall; redirect inputs asserted but ignored
        step("stall0", 1'b1, 1'b1, 1'b0, 32'h0000_0100, 26'h0, 1'b1);
        step("stall1", 1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("stall1.pc_lit", pc, 32'h0000_0008);
        step("unstall", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("unstall.pc_lit", pc, 32'h0000_000C);

        // taken branch
        step("branch", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 26'h0, 1'b1);
        chk("branch.pc_lit", pc, 32'h0000_0040);
        step("branch_tgt", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("branch_tgt.next_lit", nextInst, 32'h0000_0044);

        // jump with stall priority, from nextInst = 1000_0010
        step("to_jmp_region", 1'b0, 1'b1, 1'b0, 32'h1000_000C, 26'h0, 1'b1);
        step("jmp_fetch", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("jmp_fetch.next_lit", nextInst, 32'h1000_0010);
        step("jmp_stalled", 1'b1, 1'b0, 1'b1, 32'h0, 26'h000_0100, 1'b1);
        step("jmp_taken", 1'b0, 1'b0, 1'b1, 32'h0, 26'h000_0100, 1'b1);
        chk("jmp_taken.pc_lit", pc, 32'h1000_0400);
        step("jmp_tgt", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);

        // memory wait at 0x20, then redirect during wait
        step("to_20", 1'b0, 1'b1, 1'b0, 32'h0000_0020, 26'h0, 1'b1);
        for (int i = 0; i < 3; i++) step("wait", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        chk("wait.pc_lit", pc, 32'h0000_0020);
        step("wait_redirect", 1'b0, 1'b1, 1'b0, 32'h0000_0080, 26'h0, 1'b0);
        chk("wait_redirect.pc_lit", pc, 32'h0000_0080);

        // wrap
        step("to_top", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 26'h0, 1'b1);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        chk("wrap.pc_lit", pc, 32'h0000_0000);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            step("rand",
                 ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0),
                 {$urandom_range(32'h3FFF_FFFF), 2'b00},
                 26'($urandom),
                 ($urandom_range(3) != 0));
        end

        // async reset mid-stall, between edges
        stall = 1'b1; ready_r = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst0", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        step("post_rst1", 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
